// File: rtl/edge_event_packer.sv
// Edge event packer: numbers the samples of each line and queues edge / end-of-line entries in a FWFT FIFO.
// Optional build macro EDGE_RISING_ONLY_EN reports only rising edges (previous sample of the same line was zero).
module edge_event_packer #(
  parameter int LINE_LEN = 640,
  parameter int IDX_W    = 16,
  parameter int DEPTH    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [7:0]       edges_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index,
  output logic             out_edge,
  output logic             out_eol,
  output logic             overflow,
  output logic             busy
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);
  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, SCAN} state_e;

  typedef struct packed {
    logic             eol;
    logic             is_edge;
    logic [IDX_W-1:0] index;
  } entry_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cur_idx;
  logic             is_last;
  logic             line_open;
  logic             flag;
  logic             sample_edge;
  logic             push;
  entry_t           push_entry;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, empty, pop, push_ok;
  logic             ovf_q;
  entry_t           head;

  // In IDLE the line has not started, so the incoming sample is index 0.
  assign cur_idx = (state_q == SCAN) ? idx_q : '0;
  assign is_last = (cur_idx == LAST_IDX);
  assign flag    = |edges_in;

  // ---------------------------------------------------------------------------
  // FSM: state register, next-state logic, output logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (enb && !is_last) state_d = SCAN;
      SCAN: if (enb && is_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (enb) idx_d = is_last ? '0 : cur_idx + IDX_W'(1);
  end

`ifdef EDGE_RISING_ONLY_EN
  logic prev_q;

  // Previous flag of this line; cleared at end of line so index 0 always sees zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    prev_q <= 1'b0;
    else if (enb) prev_q <= is_last ? 1'b0 : flag;
  end
`endif

  always_comb begin
    line_open = (state_q == SCAN);
`ifdef EDGE_RISING_ONLY_EN
    sample_edge = flag && !(line_open && prev_q);
`else
    sample_edge = flag;
`endif
    push               = enb && (sample_edge || is_last);
    push_entry.eol     = is_last;
    push_entry.is_edge = sample_edge;
    push_entry.index   = cur_idx;
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign pop     = !empty && out_ready;
  assign push_ok = push && (!full || pop);

  // NOTE: storage is not reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

  assign head      = mem[rd_ptr_q];
  assign out_valid = !empty;
  assign out_index = out_valid ? head.index   : '0;
  assign out_edge  = out_valid ? head.is_edge : 1'b0;
  assign out_eol   = out_valid ? head.eol     : 1'b0;
  assign overflow  = ovf_q;
  assign busy      = line_open || out_valid;

endmodule
